// File: rtl/bloco_operativo.sv
// Datapath for a small multi-step ALU operation: X/Hreg/Sreg operands, mux-selected ALU,
// sticky overflow, saturating step count and a saida capture on the rising edge of pronto.
module bloco_operativo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  input  logic             LX,
  input  logic             LH,
  input  logic             LS,
  input  logic             H,
  input  logic             pronto,
  output logic [WIDTH-1:0] saida,
  output logic             valido,
  output logic             ovf,
  output logic [3:0]       passos
);

  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   h_q, h_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [WIDTH-1:0]   saida_q, saida_d;
  logic               valido_q, valido_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         passos_q, passos_d;
  logic               pronto_q;

  logic [WIDTH-1:0]   op_a, op_b, alu;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               alu_ovf;
  logic               load_ovf;
  logic               pronto_rise;

  always_comb begin
    op_a = '0;
    case (M0)
      2'd0:    op_a = x_q;
      2'd1:    op_a = h_q;
      2'd2:    op_a = s_q;
      default: op_a = '0;
    endcase

    op_b = '0;
    case (M1)
      2'd0:    op_b = {{(WIDTH-1){1'b0}}, 1'b1};
      2'd1:    op_b = x_q;
      2'd2:    op_b = s_q;
      default: op_b = h_q;
    endcase

    sum  = {1'b0, op_a} + {1'b0, op_b};
    prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

    alu     = op_a;
    alu_ovf = 1'b0;
    case (M2)
      2'd0: begin
        alu     = sum[WIDTH-1:0];
        alu_ovf = sum[WIDTH];
      end
      2'd1: begin
        alu     = op_a - op_b;
        alu_ovf = (op_a < op_b);
      end
      2'd2: begin
        alu     = prod[WIDTH-1:0];
        alu_ovf = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        alu     = op_a;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // The Hreg bypass path (H=0) never touches the ALU result, so it cannot flag overflow.
  assign load_ovf    = (LS | (LH & H)) & alu_ovf;
  assign pronto_rise = pronto & ~pronto_q;

  always_comb begin
    x_d      = LX ? entrada : x_q;
    h_d      = LH ? (H ? alu : op_a) : h_q;
    s_d      = LS ? alu : s_q;
    saida_d  = pronto_rise ? s_q : saida_q;
    valido_d = LX ? 1'b0 : (pronto_rise | valido_q);
    ovf_d    = LX ? load_ovf : (ovf_q | load_ovf);
    passos_d = passos_q;
    if (LX) begin
      passos_d = 4'd1;
    end else if ((LH | LS) && (passos_q != 4'd15)) begin
      passos_d = passos_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      h_q      <= '0;
      s_q      <= '0;
      saida_q  <= '0;
      valido_q <= 1'b0;
      ovf_q    <= 1'b0;
      passos_q <= 4'd0;
      pronto_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      h_q      <= h_d;
      s_q      <= s_d;
      saida_q  <= saida_d;
      valido_q <= valido_d;
      ovf_q    <= ovf_d;
      passos_q <= passos_d;
      pronto_q <= pronto;
    end
  end

  assign saida  = saida_q;
  assign valido = valido_q;
  assign ovf    = ovf_q;
  assign passos = passos_q;

endmodule

// File: tb/tb_bloco_operativo.sv
// Directed bench for bloco_operativo: a vector table for the main sequences plus
// hand-written pronto-hold, reset and saturation sequences.
module tb_bloco_operativo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] entrada;
  logic [1:0] M0, M1, M2;
  logic       LX, LH, LS, H, pronto;
  logic [7:0] saida;
  logic       valido, ovf;
  logic [3:0] passos;

  int checks = 0;
  int failures = 0;

  bloco_operativo #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .entrada(entrada),
    .M0(M0), .M1(M1), .M2(M2),
    .LX(LX), .LH(LH), .LS(LS), .H(H), .pronto(pronto),
    .saida(saida), .valido(valido), .ovf(ovf), .passos(passos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lx, lh, ls, h, pr;
    logic [1:0] m0, m1, m2;
    logic [7:0] ent;
    logic [7:0] e_saida;
    logic       e_valido, e_ovf;
    logic [3:0] e_passos;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic lx, logic lh, logic ls, logic h, logic [1:0] m0,
                              logic [1:0] m1, logic [1:0] m2, logic [7:0] ent, logic pr,
                              logic [7:0] es, logic ev, logic eo, logic [3:0] ep);
    vec_t v;
    v.lx = lx; v.lh = lh; v.ls = ls; v.h = h; v.pr = pr;
    v.m0 = m0; v.m1 = m1; v.m2 = m2; v.ent = ent;
    v.e_saida = es; v.e_valido = ev; v.e_ovf = eo; v.e_passos = ep;
    return v;
  endfunction

  task automatic drive(input logic lx, input logic lh, input logic ls, input logic h,
                       input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                       input logic [7:0] ent, input logic pr);
    LX = lx; LH = lh; LS = ls; H = h; M0 = m0; M1 = m1; M2 = m2; entrada = ent; pronto = pr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] es, input logic ev,
                     input logic eo, input logic [3:0] ep);
    checks++;
    if (saida !== es || valido !== ev || ovf !== eo || passos !== ep) begin
      failures++;
      $display("FAIL %s: got saida=%0d valido=%b ovf=%b passos=%0d, want saida=%0d valido=%b ovf=%b passos=%0d",
               nm, saida, valido, ovf, passos, es, ev, eo, ep);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Main sequence: 5 -> 25 -> 26, overflow stickiness, set-wins, H bypass, LX vs capture.
    vecs[0]  = mk(1,0,0,0, 2'd0,2'd0,2'd0, 8'd5,   0,  8'd0,   0,0, 4'd1);
    vecs[1]  = mk(0,1,0,1, 2'd0,2'd1,2'd2, 8'd0,   0,  8'd0,   0,0, 4'd2);
    vecs[2]  = mk(0,0,1,0, 2'd1,2'd0,2'd0, 8'd0,   0,  8'd0,   0,0, 4'd3);
    vecs[3]  = mk(0,0,0,0, 2'd0,2'd0,2'd0, 8'd0,   1,  8'd26,  1,0, 4'd3);
    vecs[4]  = mk(0,0,0,0, 2'd0,2'd0,2'd0, 8'd0,   1,  8'd26,  1,0, 4'd3);
    vecs[5]  = mk(1,0,0,0, 2'd0,2'd0,2'd0, 8'd200, 0,  8'd26,  0,0, 4'd1);
    vecs[6]  = mk(0,0,1,0, 2'd0,2'd1,2'd0, 8'd0,   0,  8'd26,  0,1, 4'd2);
    vecs[7]  = mk(0,0,0,0, 2'd0,2'd0,2'd0, 8'd0,   1,  8'd144, 1,1, 4'd2);
    vecs[8]  = mk(0,0,1,0, 2'd3,2'd0,2'd0, 8'd0,   0,  8'd144, 1,1, 4'd3);
    vecs[9]  = mk(1,0,1,0, 2'd0,2'd1,2'd0, 8'd7,   0,  8'd144, 0,1, 4'd1);
    vecs[10] = mk(0,0,1,0, 2'd3,2'd0,2'd3, 8'd0,   0,  8'd144, 0,1, 4'd2);
    vecs[11] = mk(1,0,0,0, 2'd0,2'd0,2'd0, 8'd200, 0,  8'd144, 0,0, 4'd1);
    vecs[12] = mk(0,1,0,0, 2'd0,2'd1,2'd2, 8'd0,   0,  8'd144, 0,0, 4'd2);
    vecs[13] = mk(0,0,1,0, 2'd1,2'd3,2'd3, 8'd0,   0,  8'd144, 0,0, 4'd3);
    vecs[14] = mk(1,0,0,0, 2'd0,2'd0,2'd0, 8'd1,   1,  8'd200, 0,0, 4'd1);
    vecs[15] = mk(0,0,0,0, 2'd0,2'd0,2'd0, 8'd0,   0,  8'd200, 0,0, 4'd1);
    vecs[16] = mk(0,0,1,0, 2'd3,2'd0,2'd1, 8'd0,   0,  8'd200, 0,1, 4'd2);
    vecs[17] = mk(0,0,0,0, 2'd0,2'd0,2'd0, 8'd0,   1,  8'd255, 1,1, 4'd2);

    rst = 1'b0;
    idle();
    #1;
    chk("reset_async", 8'd0, 0, 0, 4'd0);
    drive(1, 1, 1, 1, 2'd0, 2'd1, 2'd0, 8'd99, 1);
    tick();
    chk("no_load_in_reset", 8'd0, 0, 0, 4'd0);
    idle();
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].lx, vecs[i].lh, vecs[i].ls, vecs[i].h,
            vecs[i].m0, vecs[i].m1, vecs[i].m2, vecs[i].ent, vecs[i].pr);
      tick();
      chk($sformatf("vec%0d", i), vecs[i].e_saida, vecs[i].e_valido, vecs[i].e_ovf, vecs[i].e_passos);
    end

    // X - Sreg with Sreg=0: no borrow.
    do_reset();
    drive(1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd3, 0); tick();
    drive(0, 0, 1, 0, 2'd0, 2'd2, 2'd1, 8'd0, 0); tick();
    chk("sub_x_minus_s", 8'd0, 0, 0, 4'd2);
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0, 1); tick();
    chk("sub_x_minus_s_val", 8'd3, 1, 0, 4'd2);

    // Sreg - X with Sreg=0: 0-3 wraps to 253 with borrow.
    do_reset();
    drive(1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd3, 0); tick();
    drive(0, 0, 1, 0, 2'd2, 2'd1, 2'd1, 8'd0, 0); tick();
    chk("sub_borrow", 8'd0, 0, 1, 4'd2);
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0, 1); tick();
    chk("sub_borrow_val", 8'd253, 1, 1, 4'd2);

    // pronto held four cycles while Sreg walks 7 -> 8 -> 9: one capture only.
    do_reset();
    drive(1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd7, 0); tick();
    drive(0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 8'd0, 0); tick();
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0, 1); tick();
    chk("hold_c1", 8'd7, 1, 0, 4'd2);
    drive(0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 8'd0, 1); tick();
    chk("hold_c2", 8'd7, 1, 0, 4'd3);
    drive(0, 0, 1, 0, 2'd2, 2'd0, 2'd0, 8'd0, 1); tick();
    chk("hold_c3", 8'd7, 1, 0, 4'd4);
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0, 1); tick();
    chk("hold_c4", 8'd7, 1, 0, 4'd4);
    idle(); tick();
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0, 1); tick();
    chk("hold_recapture", 8'd9, 1, 0, 4'd4);

    // Reset pulsed between edges clears everything at once.
    idle();
    #3 rst = 1'b0;
    #1 chk("mid_reset", 8'd0, 0, 0, 4'd0);
    #1 rst = 1'b1;
    drive(1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd4, 0); tick();
    chk("after_reset_lx", 8'd0, 0, 0, 4'd1);
    drive(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0, 1); tick();
    chk("after_reset_sreg0", 8'd0, 1, 0, 4'd1);

    // Twenty load cycles saturate passos at 15.
    drive(1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd1, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 8'd0, 0); tick();
      chk($sformatf("sat%0d", i), 8'd0, 0, 0, (i + 2 > 15) ? 4'd15 : 4'(i + 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
